// File: rtl/reg_dump_unit_pkg.sv
// Shared constants and state encodings for the register dump unit.
// Optional checksum byte is enabled by the REG_DUMP_CHECKSUM_EN macro.
package reg_dump_unit_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEL,
        ST_WAITRD,
        ST_CAPTURE,
        ST_SEND,
        ST_WAITTX,
        ST_NEXT,
        ST_FINISH,
        ST_CKSUM
    } state_e;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_SEND,
        SER_WAITTX
    } ser_state_e;

endpackage

// File: rtl/reg_dump_unit_byte_serializer.sv
// Loads one word and sends it LSB byte first over a start/done UART handshake.
// single_i limits the word to its low byte.
module byte_serializer
    import reg_dump_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              single_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              tx_ready_i,
    input  logic              tx_done_i,
    output logic [BYTE_W-1:0] tx_data_o,
    output logic              tx_start_o,
    output logic              word_done_o
);

    localparam int unsigned NBYTES = DATA_W / BYTE_W;
    localparam int unsigned IDX_W  = $clog2(NBYTES + 1);

    ser_state_e        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              single_q, single_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              word_done_q, word_done_d;
    logic              last_byte;

    assign last_byte = (idx_q + IDX_W'(1)) == (single_q ? IDX_W'(1) : IDX_W'(NBYTES));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SER_IDLE;
            shreg_q     <= '0;
            idx_q       <= '0;
            single_q    <= 1'b0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            single_q    <= single_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            word_done_q <= word_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SER_IDLE:   if (load_i)     state_d = SER_SEND;
            SER_SEND:   if (tx_ready_i) state_d = SER_WAITTX;
            SER_WAITTX: if (tx_done_i)  state_d = last_byte ? SER_IDLE : SER_SEND;
            default:                    state_d = SER_IDLE;
        endcase
    end

    always_comb begin
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        single_d    = single_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        word_done_d = 1'b0;
        unique case (state_q)
            SER_IDLE: begin
                if (load_i) begin
                    shreg_d  = word_i;
                    idx_d    = '0;
                    single_d = single_i;
                end
            end
            SER_SEND: begin
                if (tx_ready_i) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = shreg_q[BYTE_W-1:0];
                end
            end
            SER_WAITTX: begin
                if (tx_done_i) begin
                    shreg_d     = shreg_q >> BYTE_W;
                    idx_d       = idx_q + IDX_W'(1);
                    word_done_d = last_byte;
                end
            end
            default: ;
        endcase
    end

    assign tx_data_o   = tx_data_q;
    assign tx_start_o  = tx_start_q;
    assign word_done_o = word_done_q;

endmodule

// File: rtl/reg_dump_unit.sv
// Debug register-file dump: sweeps all registers through the decode read port
// and streams them to the UART. REG_DUMP_CHECKSUM_EN appends an XOR checksum byte.
module reg_dump_unit
    import reg_dump_unit_pkg::*;
#(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     rd_data,
    input  logic                  tx_ready,
    input  logic                  tx_done,
    output logic [REG_ADDR_W-1:0] du_areg,
    output logic                  du_c1,
    output logic [BYTE_W-1:0]     tx_data,
    output logic                  tx_start,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned LAT_W = 2;

    state_e                state_q, state_d;
    logic [LAT_W-1:0]      cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0] du_areg_q, du_areg_d;
    logic                  du_c1_q, du_c1_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  last_reg;

    logic                  ser_load_c;
    logic                  ser_single_c;
    logic [DATA_W-1:0]     ser_word_c;
    logic                  word_done;

    assign last_reg = (du_areg_q == REG_ADDR_W'(NREGS - 1));

`ifdef REG_DUMP_CHECKSUM_EN
    logic [BYTE_W-1:0] cksum_q, cksum_d;
    logic              ck_phase_q, ck_phase_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            cksum_q    <= '0;
            ck_phase_q <= 1'b0;
        end else begin
            cksum_q    <= cksum_d;
            ck_phase_q <= ck_phase_d;
        end
    end

    always_comb begin
        cksum_d    = cksum_q;
        ck_phase_d = ck_phase_q;
        if (tx_start) cksum_d = cksum_q ^ tx_data;
        if (state_q == ST_IDLE && start) begin
            cksum_d    = '0;
            ck_phase_d = 1'b0;
        end
        if (state_q == ST_CKSUM) ck_phase_d = 1'b1;
    end

    assign ser_load_c   = (state_q == ST_CAPTURE) || (state_q == ST_CKSUM);
    assign ser_single_c = (state_q == ST_CKSUM);
    assign ser_word_c   = (state_q == ST_CKSUM) ? DATA_W'(cksum_q) : rd_data;
`else
    assign ser_load_c   = (state_q == ST_CAPTURE);
    assign ser_single_c = 1'b0;
    assign ser_word_c   = rd_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start) state_d = ST_SEL;
            ST_SEL:     state_d = ST_WAITRD;
            ST_WAITRD:  if (cnt_q <= LAT_W'(1)) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_SEND;
            ST_SEND: begin
                if (word_done) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    state_d = ck_phase_q ? ST_FINISH : ST_NEXT;
`else
                    state_d = ST_NEXT;
`endif
                end
            end
            ST_NEXT: begin
`ifdef REG_DUMP_CHECKSUM_EN
                state_d = last_reg ? ST_CKSUM : ST_SEL;
`else
                state_d = last_reg ? ST_FINISH : ST_SEL;
`endif
            end
`ifdef REG_DUMP_CHECKSUM_EN
            ST_CKSUM:   state_d = ST_SEND;
`endif
            ST_FINISH:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // du_c1 is only touched on leaving IDLE and in FINISH, so it never glitches mid-dump
    always_comb begin
        cnt_d     = cnt_q;
        du_areg_d = du_areg_q;
        du_c1_d   = du_c1_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d    = 1'b1;
                    du_c1_d   = 1'b1;
                    du_areg_d = '0;
                end
            end
            ST_SEL:    cnt_d = LAT_W'(READ_LAT);
            ST_WAITRD: if (cnt_q != '0) cnt_d = cnt_q - LAT_W'(1);
            ST_NEXT:   if (!last_reg) du_areg_d = du_areg_q + REG_ADDR_W'(1);
            ST_FINISH: begin
                done_d    = 1'b1;
                du_c1_d   = 1'b0;
                busy_d    = 1'b0;
                du_areg_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            du_areg_q <= '0;
            du_c1_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            du_areg_q <= du_areg_d;
            du_c1_q   <= du_c1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    byte_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk         (clk),
        .reset       (reset),
        .load_i      (ser_load_c),
        .single_i    (ser_single_c),
        .word_i      (ser_word_c),
        .tx_ready_i  (tx_ready),
        .tx_done_i   (tx_done),
        .tx_data_o   (tx_data),
        .tx_start_o  (tx_start),
        .word_done_o (word_done)
    );

    assign du_areg = du_areg_q;
    assign du_c1   = du_c1_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Scoreboard bench for reg_dump_unit with a register-file and UART model.
module tb_reg_dump_unit;

    localparam int unsigned NREGS  = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NB     = DATA_W / 8;
    localparam int          TX_LAT = 10;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int          TOTAL  = NREGS * NB + 1;
`else
    localparam int          TOTAL  = NREGS * NB;
`endif

    logic              clk = 1'b0;
    logic              reset, start, tx_ready, tx_done;
    logic [DATA_W-1:0] rd_data;
    logic [4:0]        du_areg;
    logic              du_c1;
    logic [7:0]        tx_data;
    logic              tx_start, busy, done;

    logic              wr_ena;
    logic [4:0]        wr_addr;
    logic [31:0]       wr_data;
    logic [31:0]       rf [NREGS];

    int  n_cmp = 0;
    int  n_fail = 0;
    int  bytes_seen = 0;
    int  done_seen = 0;
    bit  hold = 1'b0;
    logic [7:0] exp_q [$];

    reg_dump_unit #(.NREGS(NREGS), .DATA_W(DATA_W), .READ_LAT(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rd_data  (rd_data),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .du_areg  (du_areg),
        .du_c1    (du_c1),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // decode-stage register file: writes blocked while the debug port owns it
    always @(posedge clk) begin
        if (wr_ena && !du_c1) rf[wr_addr] <= wr_data;
        rd_data <= rf[du_areg];
    end

    function automatic logic [31:0] gold(input int r);
        return 32'h0A0B0C00 + 32'(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // UART model: done pulse TX_LAT cycles after each launch
    initial begin
        int pend = 0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = (pend == 1);
            if (tx_start)     pend = TX_LAT;
            else if (pend > 0) pend--;
        end
    end

    // monitor: pops expected bytes on every launch, checks done and du_c1
    initial begin
        logic       prev_start = 1'b0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                bytes_seen++;
                check("start_pulse_width", 32'(prev_start), 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %h required none at %0t", tx_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("byte%0d", bytes_seen), 32'(tx_data), 32'(e));
                end
            end
            if (hold) check("hold_no_start", 32'(tx_start), 32'd0);
            if (busy) check("du_c1_held", 32'(du_c1), 32'd1);
            if (done) begin
                done_seen++;
                check("done_busy", 32'(busy), 32'd0);
                check("done_du_c1", 32'(du_c1), 32'd0);
                check("done_all_bytes", 32'(exp_q.size()), 32'd0);
            end
            prev_start = tx_start;
        end
    end

    task automatic push_dump();
        logic [7:0] b;
        logic [7:0] cs = 8'h00;
        for (int r = 0; r < int'(NREGS); r++) begin
            for (int k = 0; k < int'(NB); k++) begin
                b = 8'(gold(r) >> (8 * k));
                cs ^= b;
                exp_q.push_back(b);
            end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    task automatic wait_bytes(input int n, input string what);
        int c = 0;
        while (bytes_seen < n && c < 5000) begin
            @(negedge clk);
            c++;
        end
        if (bytes_seen < n) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout_%s: bytes %0d required %0d", what, bytes_seen, n);
        end
    endtask

    task automatic wait_done(input int prev, input string what);
        int c = 0;
        while (done_seen == prev && c < 5000) begin
            @(negedge clk);
            c++;
        end
        if (done_seen == prev) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout_%s: no done pulse within budget", what);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    initial begin
        int base, d0;
        reset = 1'b1; start = 1'b0; tx_ready = 1'b1;
        wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_du_areg", 32'(du_areg), 32'd0);
        check("rst_du_c1", 32'(du_c1), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < int'(NREGS); i++) begin
            @(negedge clk);
            wr_ena = 1'b1; wr_addr = 5'(i); wr_data = gold(i);
        end
        @(negedge clk) wr_ena = 1'b0;

        // dump 1: start-while-busy, blocked write to R5, tx_ready stall
        push_dump();
        base = bytes_seen; d0 = done_seen;
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        check("start_du_c1", 32'(du_c1), 32'd1);
        check("start_du_areg", 32'(du_areg), 32'd0);
        wait_bytes(base + 10, "d1_10");
        pulse_start();
        @(negedge clk) begin wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; end
        @(negedge clk) wr_ena = 1'b0;
        wait_bytes(base + 20, "d1_20");
        @(negedge clk) tx_ready = 1'b0;
        @(negedge clk) hold = 1'b1;
        repeat (48) @(negedge clk);
        hold = 1'b0; tx_ready = 1'b1;
        wait_done(d0, "d1_done");
        repeat (5) @(negedge clk);
        check("d1_byte_count", 32'(bytes_seen - base), 32'(TOTAL));
        check("d1_done_count", 32'(done_seen - d0), 32'd1);
        check("r5_write_blocked", rf[5], 32'h0A0B0C05);
        check("d1_end_busy", 32'(busy), 32'd0);
        check("d1_end_du_c1", 32'(du_c1), 32'd0);

        // dump 2: reset after 37 bytes
        push_dump();
        base = bytes_seen; d0 = done_seen;
        pulse_start();
        wait_bytes(base + 37, "d2_37");
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check("abort_du_c1", 32'(du_c1), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_du_areg", 32'(du_areg), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        exp_q.delete();
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(done_seen - d0), 32'd0);
        check("abort_byte_count", 32'(bytes_seen - base), 32'd37);

        // dump 3: must restart from R0
        push_dump();
        base = bytes_seen; d0 = done_seen;
        pulse_start();
        wait_done(d0, "d3_done");
        repeat (5) @(negedge clk);
        check("d3_byte_count", 32'(bytes_seen - base), 32'(TOTAL));
        check("d3_done_count", 32'(done_seen - d0), 32'd1);
        check("d3_end_du_areg", 32'(du_areg), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
